// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed multiplier / BCD display path.
//   state_t    : controller states
//   SEG_*      : active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   seg_of()   : BCD digit -> segment pattern, anything above 9 is blanked
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_CONV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// One BCD digit to an active-low common-anode seven-segment pattern.
//   bcd   in  4  BCD digit
//   blank in  1  force all segments off
//   seg   out 7  {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7 (
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);
  import mult_pkg::*;

  always_comb begin
    seg = blank ? SEG_BLANK : seg_of(bcd);
  end

endmodule

// File: rtl/signed_mult_bcd_seq.sv
// Sequential signed multiplier with start/busy/done handshake, serial shift-add
// core and serial double-dabble conversion feeding DIGITS seven-segment displays.
//   clk, rst       clock, synchronous active-high reset
//   A, B           signed operands, sampled only when a start is accepted
//   start          request, accepted only while idle
//   busy, done     busy from accept until the end of the one-cycle done pulse
//   product, neg   signed product and its sign (zero is never negative)
//   bcd            BCD of |product|, digit 0 in [3:0]
//   displays       active-low {g..a} per digit, digit 0 in [6:0]
//
// state   | meaning
// IDLE    | waiting for start
// MUL     | WIDTH shift-add steps on the magnitudes
// CONV    | 2*WIDTH double-dabble shifts, outputs loaded on the last one
// DONE    | one-cycle done pulse
module signed_mult_bcd_seq #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 5,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      A,
  input  logic [WIDTH-1:0]      B,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [2*WIDTH-1:0]    product,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   displays
);
  import mult_pkg::*;

  localparam int PW    = 2*WIDTH;
  localparam int BW    = 4*DIGITS;
  localparam int CNT_W = $clog2(PW+1);
  localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(WIDTH-1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(PW-1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    acc, acc_nx, mcand_sh, bin_sr;
  logic [WIDTH-1:0] mplier, a_mag, b_mag;
  logic             sign;
  logic [BW-1:0]    bcd_sr, bcd_adj, bcd_nx;

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is the
  // correct unsigned magnitude.
  assign a_mag  = A[WIDTH-1] ? -A : A;
  assign b_mag  = B[WIDTH-1] ? -B : B;
  assign acc_nx = mplier[0] ? acc + mcand_sh : acc;

  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
    bcd_nx = {bcd_adj[BW-2:0], bin_sr[PW-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
    case (state)
      ST_IDLE: if (start) state_nx = ST_MUL;
      ST_MUL:  if (cnt == MUL_LAST) state_nx = ST_CONV;
      ST_CONV: if (cnt == CONV_LAST) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      mcand_sh <= '0;
      mplier   <= '0;
      sign     <= 1'b0;
      bin_sr   <= '0;
      bcd_sr   <= '0;
      product  <= '0;
      neg      <= 1'b0;
      bcd      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand_sh <= PW'(a_mag);
            mplier   <= b_mag;
            sign     <= A[WIDTH-1] ^ B[WIDTH-1];
            acc      <= '0;
            cnt      <= '0;
          end
        end
        ST_MUL: begin
          acc      <= acc_nx;
          mcand_sh <= mcand_sh << 1;
          mplier   <= mplier >> 1;
          if (cnt == MUL_LAST) begin
            cnt    <= '0;
            bin_sr <= acc_nx;
            bcd_sr <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CONV: begin
          bin_sr <= {bin_sr[PW-2:0], 1'b0};
          bcd_sr <= bcd_nx;
          cnt    <= cnt + 1'b1;
          if (cnt == CONV_LAST) begin
            // acc still holds the magnitude; a zero result keeps neg low.
            bcd     <= bcd_nx;
            neg     <= sign & (|acc);
            product <= (sign & (|acc)) ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic blank;
    if (i == 0) begin : g_lsd
      assign blank = 1'b0;
    end else begin : g_upper
      assign blank = (BLANK_LZ != 0) && (bcd[BW-1:4*i] == '0);
    end
    bcd_to_seg7 u_seg (
      .bcd   (bcd[4*i +: 4]),
      .blank (blank),
      .seg   (displays[7*i +: 7])
    );
  end

endmodule

// File: tb/tb_signed_mult_bcd_seq.sv
module tb_signed_mult_bcd_seq;

  typedef struct {
    logic [15:0] p;
    logic        n;
    logic [19:0] bc;
    logic [34:0] sg;
    int          acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  A, B;
  logic        start;
  logic        busy, done, neg;
  logic [15:0] product;
  logic [19:0] bcd;
  logic [34:0] displays;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  localparam logic [34:0] SEG_RST = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};

  signed_mult_bcd_seq #(.WIDTH(8), .DIGITS(5), .BLANK_LZ(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .neg      (neg),
    .bcd      (bcd),
    .displays (displays)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending operation", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("product", 64'(product), 64'(mon_e.p));
        check("neg", 64'(neg), 64'(mon_e.n));
        check("bcd", 64'(bcd), 64'(mon_e.bc));
        check("displays", 64'(displays), 64'(mon_e.sg));
        check("latency", 64'(cyc - mon_e.acc_cyc), 64'd24);
        check("busy_at_done", 64'(busy), 64'd1);
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, output int acc_cyc);
    @(posedge clk); #1;
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input int d0);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) got = 1'b1;
    end
    check("done_seen", 64'(got), 64'd1);
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                        input logic n, input logic [19:0] bc, input logic [34:0] sg);
    exp_t e;
    int   ac;
    int   d0;
    d0 = done_cnt;
    issue(a, b, ac);
    e.p = p; e.n = n; e.bc = bc; e.sg = sg; e.acc_cyc = ac;
    exp_q.push_back(e);
    wait_done(d0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_product"}, 64'(product), 64'd0);
    check({tag, "_neg"}, 64'(neg), 64'd0);
    check({tag, "_bcd"}, 64'(bcd), 64'd0);
    check({tag, "_displays"}, 64'(displays), 64'(SEG_RST));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   ac, d0;
    bit   dropped;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    run_op(8'd5,  8'hFD, 16'hFFF1, 1'b1, 20'h00015, {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h12});
    run_op(8'h80, 8'h80, 16'h4000, 1'b0, 20'h16384, {7'h79, 7'h02, 7'h30, 7'h00, 7'h19});
    run_op(8'd0,  8'hF9, 16'h0000, 1'b0, 20'h00000, SEG_RST);
    run_op(8'hFB, 8'd0,  16'h0000, 1'b0, 20'h00000, SEG_RST);
    run_op(8'h7F, 8'h80, 16'hC080, 1'b1, 20'h16256, {7'h79, 7'h02, 7'h24, 7'h12, 7'h02});
    run_op(8'd10, 8'd10, 16'h0064, 1'b0, 20'h00100, {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40});
    run_op(8'hFF, 8'hFF, 16'h0001, 1'b0, 20'h00001, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79});

    // Start while busy is ignored; busy stays high until the single done.
    d0 = done_cnt;
    issue(8'd7, 8'd9, ac);
    e.p = 16'd63; e.n = 1'b0; e.bc = 20'h00063;
    e.sg = {7'h7F, 7'h7F, 7'h7F, 7'h02, 7'h30}; e.acc_cyc = ac;
    exp_q.push_back(e);
    repeat (4) @(posedge clk);
    #1 A = 8'd2; B = 8'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dropped = 1'b0;
    for (int i = 0; i < 40 && done_cnt == d0; i++) begin
      @(negedge clk); #1;
      if (!busy) dropped = 1'b1;
    end
    check("busy_never_drops", 64'(dropped), 64'd0);
    @(negedge clk);
    check("busy_after_ignored", 64'(busy), 64'd0);
    repeat (30) @(negedge clk);
    check("single_done", 64'(done_cnt - d0), 64'd1);

    // Reset during CONV aborts the operation without a done.
    d0 = done_cnt;
    issue(8'd100, 8'd100, ac);
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("abort");
    repeat (30) @(negedge clk);
    check("no_done_after_abort", 64'(done_cnt - d0), 64'd0);

    run_op(8'hFF, 8'd1, 16'hFFFF, 1'b1, 20'h00001, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79});

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
